// File: rtl/xor_serial_arbiter.sv
// xor_serial_arbiter
// Time-shares one single-bit XOR gate among NREQ requesters. A round-robin
// arbiter grants one requester. Its two WIDTH-bit operands are then streamed
// LSB-first through the gate, one bit per clock. The result is returned with a
// one-cycle completion pulse that carries the requester index.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous active-high reset
//   REQ      per-requester request level (bit i = requester i)
//   A_IN     operand A, requester i at [i*WIDTH +: WIDTH]
//   B_IN     operand B, same packing
//   GNT      one-hot grant, zero when idle
//   BUSY     high while shifting or signalling completion
//   F_OUT    last completed result, held until the next completion
//   DONE     one-cycle completion pulse
//   DONE_ID  index of the requester whose result is on F_OUT
module xor_serial_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*WIDTH-1:0]     A_IN,
    input  logic [NREQ*WIDTH-1:0]     B_IN,
    output logic [NREQ-1:0]           GNT,
    output logic                      BUSY,
    output logic [WIDTH-1:0]          F_OUT,
    output logic                      DONE,
    output logic [$clog2(NREQ)-1:0]   DONE_ID
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q;
    logic [IDW-1:0]     last_q;
    logic [IDW-1:0]     winner_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    // The oldest result bit is never read before it is shifted out, so only
    // WIDTH-1 bits are stored. The incoming gate bit completes the word.
    logic [WIDTH-2:0]   r_sh_q;

    logic               found;
    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     idx;
    int unsigned        pick_base;
    logic               f;
    logic [WIDTH-1:0]   r_next;

    // Round-robin search that starts just after the last winner. IDW-bit
    // addition wraps naturally because NREQ is a power of two.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        idx   = last_q;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = last_q + IDW'(i);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_base = 32'(pick) * WIDTH;
    end

    // The shared gate
    assign f      = a_sh_q[0] ^ b_sh_q[0];
    assign r_next = {f, r_sh_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            last_q   <= IDW'(NREQ - 1);
            winner_q <= '0;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            GNT      <= '0;
            BUSY     <= 1'b0;
            F_OUT    <= '0;
            DONE     <= 1'b0;
            DONE_ID  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        winner_q <= pick;
                        a_sh_q   <= A_IN[pick_base +: WIDTH];
                        b_sh_q   <= B_IN[pick_base +: WIDTH];
                        cnt_q    <= '0;
                        GNT      <= NREQ'(1) << pick;
                        BUSY     <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    if (!REQ[winner_q]) begin
                        // Abort: drop the operation silently, F_OUT/DONE_ID keep old values
                        GNT     <= '0;
                        BUSY    <= 1'b0;
                        last_q  <= winner_q;
                        state_q <= StIdle;
                    end else begin
                        a_sh_q <= a_sh_q >> 1;
                        b_sh_q <= b_sh_q >> 1;
                        r_sh_q <= r_next[WIDTH-1:1];
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            F_OUT   <= r_next;
                            DONE_ID <= winner_q;
                            DONE    <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    DONE    <= 1'b0;
                    GNT     <= '0;
                    BUSY    <= 1'b0;
                    last_q  <= winner_q;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_serial_arbiter.sv
// Directed bench for xor_serial_arbiter (WIDTH=8, NREQ=4).
module tb_xor_serial_arbiter;

    localparam int W = 8;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   REQ;
    logic [N*W-1:0] A_IN;
    logic [N*W-1:0] B_IN;
    logic [N-1:0]   GNT;
    logic           BUSY;
    logic [W-1:0]   F_OUT;
    logic           DONE;
    logic [1:0]     DONE_ID;

    int checks = 0;
    int errors = 0;

    xor_serial_arbiter #(
        .WIDTH (W),
        .NREQ  (N)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .A_IN    (A_IN),
        .B_IN    (B_IN),
        .GNT     (GNT),
        .BUSY    (BUSY),
        .F_OUT   (F_OUT),
        .DONE    (DONE),
        .DONE_ID (DONE_ID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        A_IN[id*W +: W] = a;
        B_IN[id*W +: W] = b;
    endtask

    // One complete uncontended operation on requester id.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp);
        REQ = 4'b0001 << id;
        set_ops(id, a, b);
        step();
        chk("op_gnt", 32'(GNT), 32'(1) << id);
        chk("op_busy", 32'(BUSY), 32'd1);
        repeat (7) step();
        chk("op_done_early", 32'(DONE), 32'd0);
        step();
        chk("op_done", 32'(DONE), 32'd1);
        chk("op_f_out", 32'(F_OUT), 32'(exp));
        chk("op_done_id", 32'(DONE_ID), 32'(id));
        chk("op_gnt_held", 32'(GNT), 32'(1) << id);
        step();
        chk("op_done_clr", 32'(DONE), 32'd0);
        chk("op_gnt_clr", 32'(GNT), 32'd0);
        chk("op_busy_clr", 32'(BUSY), 32'd0);
        REQ = '0;
    endtask

    initial begin
        int           dn;
        int           n;
        int           cyc  [5];
        logic [1:0]   ids  [5];
        logic [7:0]   fo   [5];
        logic [7:0]   rr_f [5];

        RST  = 1'b1;
        REQ  = '0;
        A_IN = '0;
        B_IN = '0;
        step();
        step();
        chk("rst_gnt", 32'(GNT), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_f_out", 32'(F_OUT), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_done_id", 32'(DONE_ID), 32'd0);
        RST = 1'b0;

        // Single op, 0xA5 ^ 0x3C = 0x99
        run_op(0, 8'hA5, 8'h3C, 8'h99);

        // Bit coverage on requester 2
        run_op(2, 8'hFF, 8'h00, 8'hFF);
        run_op(2, 8'hFF, 8'hFF, 8'h00);
        run_op(2, 8'h0F, 8'h33, 8'h3C);
        run_op(2, 8'h00, 8'h00, 8'h00);

        // Abort: restore F_OUT=0x99, then contention 0110 grants requester 1
        run_op(0, 8'hA5, 8'h3C, 8'h99);
        REQ = 4'b0110;
        set_ops(1, 8'hFF, 8'h00);
        set_ops(2, 8'h0F, 8'h33);
        step();
        chk("ab_gnt1", 32'(GNT), 32'h2);
        repeat (3) step();
        REQ = 4'b0100;
        step();
        chk("ab_gnt_clr", 32'(GNT), 32'd0);
        chk("ab_busy_clr", 32'(BUSY), 32'd0);
        chk("ab_no_done", 32'(DONE), 32'd0);
        chk("ab_f_out_kept", 32'(F_OUT), 32'h99);
        chk("ab_done_id_kept", 32'(DONE_ID), 32'd0);
        step();
        chk("ab_gnt2", 32'(GNT), 32'h4);
        repeat (8) step();
        chk("ab2_done", 32'(DONE), 32'd1);
        chk("ab2_f_out", 32'(F_OUT), 32'h3C);
        chk("ab2_done_id", 32'(DONE_ID), 32'd2);
        step();
        REQ = '0;

        // Operand hold: inputs scrambled every cycle after the grant
        REQ = 4'b1000;
        set_ops(3, 8'h12, 8'h34);
        step();
        chk("hold_gnt", 32'(GNT), 32'h8);
        for (int i = 0; i < 8; i++) begin
            A_IN = $urandom;
            B_IN = $urandom;
            step();
        end
        chk("hold_done", 32'(DONE), 32'd1);
        chk("hold_f_out", 32'(F_OUT), 32'h26);
        chk("hold_done_id", 32'(DONE_ID), 32'd3);
        step();
        REQ = '0;

        // Asynchronous reset in the middle of a shift
        REQ = 4'b0001;
        set_ops(0, 8'hFF, 8'h00);
        step();
        repeat (3) step();
        chk("mid_busy_pre", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        chk("arst_gnt", 32'(GNT), 32'd0);
        chk("arst_busy", 32'(BUSY), 32'd0);
        chk("arst_f_out", 32'(F_OUT), 32'd0);
        chk("arst_done", 32'(DONE), 32'd0);
        chk("arst_done_id", 32'(DONE_ID), 32'd0);
        REQ = '0;
        step();
        step();
        RST = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (DONE) dn++;
        end
        chk("arst_no_done", 32'(dn), 32'd0);

        // Round-robin with all requesters active; requester 0 wins first
        A_IN = 32'h08040201;
        B_IN = 32'hF0F0F0F0;
        rr_f[0] = 8'hF1;
        rr_f[1] = 8'hF2;
        rr_f[2] = 8'hF4;
        rr_f[3] = 8'hF8;
        rr_f[4] = 8'hF1;
        REQ = 4'b1111;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (DONE) begin
                if (n < 5) begin
                    cyc[n] = c;
                    ids[n] = DONE_ID;
                    fo[n]  = F_OUT;
                end
                n++;
            end
        end
        REQ = '0;
        chk("rr_count", 32'(n), 32'd5);
        if (n >= 5) begin
            chk("rr_first_cycle", 32'(cyc[0]), 32'd8);
            for (int i = 0; i < 5; i++) begin
                chk("rr_id", 32'(ids[i]), 32'(i % 4));
                chk("rr_f_out", 32'(fo[i]), 32'(rr_f[i]));
                if (i > 0) chk("rr_gap", 32'(cyc[i] - cyc[i-1]), 32'd10);
            end
        end
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
